// File: rtl/tinker_regfile_sb_pkg.sv
// Shared Tinker core constants: register file geometry, stack pointer
// reset value and the scoreboard counter operation encoding.
package tinker_pkg;

    localparam int unsigned TINKER_NUM_REGS = 32;
    localparam int unsigned TINKER_DATA_W   = 64;
    localparam int unsigned TINKER_SP_INIT  = 524288;
    localparam int unsigned SP_IDX          = TINKER_NUM_REGS - 1;

    // Net effect of one cycle's set/clear traffic on the pending counter
    typedef enum logic [1:0] {
        SB_HOLD = 2'b00,
        SB_DEC  = 2'b01,
        SB_INC  = 2'b10,
        SB_SWAP = 2'b11
    } sb_op_e;

    function automatic sb_op_e sb_op(input logic inc, input logic dec);
        return sb_op_e'({inc, dec});
    endfunction

endpackage

// File: rtl/tinker_regfile_sb_scoreboard.sv
// Pending-register scoreboard for long-latency producers: one bit per
// register plus a running count, bounded by MAX_PEND outstanding marks.
module tinker_scoreboard
    import tinker_pkg::*;
#(
    parameter int unsigned NUM_REGS = TINKER_NUM_REGS,
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned AW       = $clog2(NUM_REGS),
    parameter int unsigned CW       = $clog2(MAX_PEND + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [CW-1:0]       pend_cnt_o,
    output logic                sb_set_rdy_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;

    logic                set_hit;
    logic                clr_hit;
    logic                set_acc;
    logic                inc;
    logic                dec;
    logic                same_addr;
    logic [NUM_REGS-1:0] set_oh;
    logic [NUM_REGS-1:0] clr_oh;

    assign set_hit   = pend_q[sb_set_addr];
    assign clr_hit   = wr_en && pend_q[wr_addr];
    assign same_addr = (sb_set_addr == wr_addr);

    // A same-cycle clear frees a slot, so a full scoreboard may still accept
    assign sb_set_rdy_o = (cnt_q < CW'(MAX_PEND)) || set_hit || clr_hit;

    assign set_acc = sb_set_en && sb_set_rdy_o;
    assign inc     = set_acc && !set_hit;
    assign dec     = clr_hit && !(set_acc && same_addr);

    assign set_oh = set_acc ? (NUM_REGS'(1) << sb_set_addr) : '0;
    assign clr_oh = clr_hit ? (NUM_REGS'(1) << wr_addr) : '0;

    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (flush) begin
            pend_d = '0;
            cnt_d  = '0;
        end else begin
            pend_d = (pend_q & ~clr_oh) | set_oh;
            unique case (sb_op(inc, dec))
                SB_INC:  cnt_d = cnt_q + CW'(1);
                SB_DEC:  cnt_d = cnt_q - CW'(1);
                SB_SWAP: cnt_d = cnt_q;
                SB_HOLD: cnt_d = cnt_q;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_o  = pend_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/tinker_regfile_sb.sv
// Multi-read-port register file with load/return scoreboard.
// Define TINKER_REGFILE_BYPASS_EN for same-cycle write-through reads.
module tinker_regfile_sb
    import tinker_pkg::*;
#(
    parameter int unsigned NUM_REGS = TINKER_NUM_REGS,
    parameter int unsigned DATA_W   = TINKER_DATA_W,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned MAX_PEND = 4,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(TINKER_SP_INIT),
    localparam int unsigned AW = $clog2(NUM_REGS),
    localparam int unsigned CW = $clog2(MAX_PEND + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr,
    output logic                     sb_set_rdy,
    input  logic                     flush,
    output logic [DATA_W-1:0]        sp_val,
    output logic [CW-1:0]            pend_cnt,
    output logic                     stall
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == NUM_REGS - 1) ? SP_INIT : '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    tinker_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .MAX_PEND (MAX_PEND),
        .AW       (AW),
        .CW       (CW)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .sb_set_en    (sb_set_en),
        .sb_set_addr  (sb_set_addr),
        .flush        (flush),
        .pending_o    (pending),
        .pend_cnt_o   (pend_cnt),
        .sb_set_rdy_o (sb_set_rdy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
`ifdef TINKER_REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*AW +: AW]];
                rd_busy[k]                  = pending[rd_addr[k*AW +: AW]];
            end
`else
            rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*AW +: AW]];
            rd_busy[k]                  = pending[rd_addr[k*AW +: AW]];
`endif
        end
    end

    assign stall  = |rd_busy;
    assign sp_val = regs_q[NUM_REGS-1];

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Randomized and directed checks of tinker_regfile_sb against a
// behavioural register/scoreboard model.
module tb_tinker_regfile_sb;

    localparam int NR = 32;
    localparam int DW = 64;
    localparam int NP = 3;
    localparam int AW = 5;
    localparam int CW = 3;
    localparam int MP = 4;
    localparam logic [63:0] SP = 64'd524288;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0] rd_busy;
    logic          sb_set_en;
    logic [AW-1:0] sb_set_addr;
    logic          sb_set_rdy;
    logic          flush;
    logic [DW-1:0] sp_val;
    logic [CW-1:0] pend_cnt;
    logic          stall;

    tinker_regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_set_rdy  (sb_set_rdy),
        .flush       (flush),
        .sp_val      (sp_val),
        .pend_cnt    (pend_cnt),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    logic [63:0] m_reg [NR];
    bit          m_pend [NR];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NR; i++) c += m_pend[i] ? 1 : 0;
        return c;
    endfunction

    function automatic bit m_rdy();
        return (m_cnt() < MP) || m_pend[sb_set_addr] ||
               (wr_en && m_pend[wr_addr]);
    endfunction

    function automatic logic [AW-1:0] ra(input int k);
        return rd_addr[k*AW +: AW];
    endfunction

    function automatic logic [63:0] rdat(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic check_outputs();
        logic [63:0] ed;
        bit eb;
        bit es = 0;
        for (int k = 0; k < NP; k++) begin
            ed = m_reg[ra(k)];
            eb = m_pend[ra(k)];
`ifdef TINKER_REGFILE_BYPASS_EN
            if (wr_en && wr_addr == ra(k)) begin
                ed = wr_data;
                eb = 0;
            end
`endif
            es |= eb;
            chk($sformatf("rd_data%0d", k), rdat(k), ed);
            chk($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(eb));
        end
        chk("stall", 64'(stall), 64'(es));
        chk("sp_val", sp_val, m_reg[NR-1]);
        chk("pend_cnt", 64'(pend_cnt), 64'(m_cnt()));
        chk("sb_set_rdy", 64'(sb_set_rdy), 64'(m_rdy()));
    endtask

    task automatic model_edge();
        bit rdy = m_rdy();
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = (i == NR - 1) ? SP : 64'd0;
                m_pend[i] = 0;
            end
        end else begin
            if (wr_en) m_reg[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < NR; i++) m_pend[i] = 0;
            end else begin
                if (wr_en) m_pend[wr_addr] = 0;
                if (sb_set_en && rdy) m_pend[sb_set_addr] = 1;
            end
        end
    endtask

    task automatic cycle(input bit do_chk);
        @(negedge clk);
        if (do_chk) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en     = 0;
        sb_set_en = 0;
        flush     = 0;
        reset     = 1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_reg(input int a);
        sb_set_en   = 1;
        sb_set_addr = AW'(a);
        cycle(1);
        sb_set_en = 0;
    endtask

    initial begin
        idle();
        reset = 0;
        wr_addr = '0;
        wr_data = '0;
        sb_set_addr = '0;
        rd_addr = '0;
        cycle(0);
        reset = 1;

        // reset state
        rd_addr = {AW'(0), AW'(5), AW'(31)};
        settle();
        chk("rst_sp_read", rdat(0), SP);
        chk("rst_r5_read", rdat(1), 64'd0);
        chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
        chk("rst_sb_rdy", 64'(sb_set_rdy), 64'd1);
        cycle(1);

        // write-through vs registered read
        wr_en = 1; wr_addr = 7; wr_data = 64'hDEAD;
        rd_addr = {AW'(1), AW'(2), AW'(7)};
        settle();
`ifdef TINKER_REGFILE_BYPASS_EN
        chk("wr_same_cycle", rdat(0), 64'hDEAD);
`else
        chk("wr_same_cycle", rdat(0), 64'd0);
`endif
        cycle(1);
        wr_en = 0;
        settle();
        chk("wr_next_cycle", rdat(0), 64'hDEAD);
        cycle(1);

        // scoreboard set then writeback clear
        rd_addr = {AW'(0), AW'(0), AW'(3)};
        set_reg(3);
        settle();
        chk("r3_busy", 64'(rd_busy[0]), 64'd1);
        chk("r3_stall", 64'(stall), 64'd1);
        wr_en = 1; wr_addr = 3; wr_data = 64'd9;
        cycle(1);
        wr_en = 0;
        settle();
        chk("r3_cleared", 64'(rd_busy[0]), 64'd0);
        chk("r3_data", rdat(0), 64'd9);
        cycle(1);

        // fill to MAX_PEND
        set_reg(1); set_reg(2); set_reg(4); set_reg(5);
        sb_set_en = 1; sb_set_addr = 6;
        settle();
        chk("full_cnt", 64'(pend_cnt), 64'd4);
        chk("full_rdy", 64'(sb_set_rdy), 64'd0);
        cycle(1);
        wr_en = 1; wr_addr = 1; wr_data = 64'h11;
        settle();
        chk("swap_rdy", 64'(sb_set_rdy), 64'd1);
        cycle(1);
        wr_en = 0; sb_set_en = 0;
        rd_addr = {AW'(1), AW'(0), AW'(6)};
        settle();
        chk("swap_cnt", 64'(pend_cnt), 64'd4);
        chk("r6_busy", 64'(rd_busy[0]), 64'd1);
        chk("r1_free", 64'(rd_busy[2]), 64'd0);
        cycle(1);

        // set wins over same-address clear; flush beats set
        flush = 1;
        cycle(1);
        flush = 0;
        set_reg(8);
        sb_set_en = 1; sb_set_addr = 8;
        wr_en = 1; wr_addr = 8; wr_data = 64'h88;
        cycle(1);
        wr_en = 0; sb_set_en = 0;
        rd_addr = {AW'(0), AW'(9), AW'(8)};
        settle();
        chk("r8_pending", 64'(rd_busy[0]), 64'd1);
        chk("r8_cnt", 64'(pend_cnt), 64'd1);
        flush = 1; sb_set_en = 1; sb_set_addr = 9;
        cycle(1);
        flush = 0; sb_set_en = 0;
        settle();
        chk("flush_cnt", 64'(pend_cnt), 64'd0);
        chk("r9_clear", 64'(rd_busy[1]), 64'd0);
        cycle(1);

        // reset overrides pending and write
        set_reg(10); set_reg(11); set_reg(12);
        reset = 0; wr_en = 1; wr_addr = 31; wr_data = 64'h1234;
        cycle(1);
        reset = 1; wr_en = 0;
        rd_addr = {AW'(10), AW'(11), AW'(12)};
        settle();
        chk("rst2_cnt", 64'(pend_cnt), 64'd0);
        chk("rst2_sp", sp_val, SP);
        chk("rst2_stall", 64'(stall), 64'd0);
        cycle(1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            wr_en       = $urandom_range(0, 2) != 0;
            wr_addr     = AW'($urandom_range(0, 15));
            wr_data     = {$urandom, $urandom};
            sb_set_en   = $urandom_range(0, 1) != 0;
            sb_set_addr = AW'($urandom_range(0, 15));
            for (int k = 0; k < NP; k++)
                rd_addr[k*AW +: AW] = AW'($urandom_range(0, 31));
            cycle(1);
        end
        idle();
        cycle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tinker_regfile_sb.md
TINKER_REGFILE_SB -- requirements
Module: tinker_regfile_sb

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers (power of two, >=4).
REQ-002 Parameter DATA_W, default 64, register width in bits.
REQ-003 Parameter NUM_RD, default 3, number of independent read ports.
REQ-004 Parameter MAX_PEND, default 4, maximum simultaneously pending (scoreboarded) registers.
REQ-005 Parameter SP_INIT, default 524288, reset value of register NUM_REGS-1 (stack pointer).
REQ-006 Local AW = clog2(NUM_REGS); CW = clog2(MAX_PEND+1).
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-009 wr_en / wr_addr / wr_data  input  1 / AW / DATA_W  writeback port.
REQ-010 rd_addr  input  NUM_RD*AW  packed read addresses, port k at [k*AW +: AW].
REQ-011 rd_data  output  NUM_RD*DATA_W  packed read data, combinational.
REQ-012 rd_busy  output  NUM_RD  port k address currently pending.
REQ-013 sb_set_en / sb_set_addr  input  1 / AW  issue of a long-latency producer (load, return) for a register.
REQ-014 sb_set_rdy  output  1  scoreboard can accept a set this cycle.
REQ-015 flush  input  1  discard all pending marks (branch flush).
REQ-016 sp_val  output  DATA_W  register NUM_RD-independent view of register NUM_REGS-1.
REQ-017 pend_cnt  output  CW  number of pending registers.
REQ-018 stall  output  1  OR of rd_busy over ports whose address is valid (all ports).

Function
REQ-019 Write: wr_en high at rising edge writes wr_data to wr_addr; all registers writable, including 0.
REQ-020 Read: rd_data port k = register[rd_addr k], zero-latency, independent per port.
REQ-021 Scoreboard: one pending bit per register; rd_busy k = pending[rd_addr k] (combinational).
REQ-022 Set accepted when sb_set_en && sb_set_rdy; marks pending[sb_set_addr] at next edge.
REQ-023 sb_set_rdy = (pend_cnt < MAX_PEND) || (sb_set_addr already pending) || (wr_en && pending[wr_addr]).
REQ-024 Set to an already-pending register: bit stays set, pend_cnt unchanged.
REQ-025 wr_en to a pending register clears its bit and decrements pend_cnt.
REQ-026 Simultaneous set and clear of same address: set wins, bit remains 1, pend_cnt unchanged.
REQ-027 Simultaneous set and clear of different addresses: pend_cnt unchanged net.
REQ-028 flush: all pending bits cleared, pend_cnt = 0 next cycle; flush overrides same-cycle set and clear.
REQ-029 pend_cnt never exceeds MAX_PEND nor underflows; it always equals popcount(pending).
REQ-030 Set with sb_set_en high and sb_set_rdy low is dropped; requester holds and retries.

Reset
REQ-031 reset low at edge: registers 0..NUM_REGS-2 = 0, register NUM_REGS-1 = SP_INIT, pending = 0, pend_cnt = 0.
REQ-032 Reset overrides wr_en, sb_set_en and flush in the same cycle; during reset rd_busy = 0, stall = 0, sb_set_rdy = 1 after first edge.

Configuration
REQ-033 Macro TINKER_REGFILE_BYPASS_EN defined: rd_data k = wr_data when wr_en && wr_addr == rd_addr k (same-cycle write-through), and rd_busy k is 0 for that port that cycle.
REQ-034 Macro undefined: rd_data returns stored value only; new value visible the cycle after the write; rd_busy reflects pending before clear.

Structure
REQ-035 Shared package tinker_pkg holds DATA_W default, NUM_REGS default, SP_INIT default and SP_IDX constant; the block imports it.
REQ-036 One sub-module tinker_scoreboard (pending bits, pend_cnt, sb_set_rdy); storage and read muxes stay in the parent.

Verification
REQ-037 Reset low 1 cycle -> rd_addr=31 reads 524288, rd_addr=5 reads 0, pend_cnt=0.
REQ-038 wr r7=0xDEAD, same-cycle read r7 -> 0xDEAD with BYPASS_EN, 0 without; next cycle 0xDEAD either way.
REQ-039 sb_set r3; read r3 next cycle -> rd_busy=1, stall=1; wr r3=9 -> following cycle rd_busy=0, data 9.
REQ-040 Set r1,r2,r4,r5 (MAX_PEND=4) -> pend_cnt=4, sb_set_rdy=0 for r6; set r6 with wr r1 same cycle -> accepted, pend_cnt=4.
REQ-041 Set r8 and wr r8 same cycle -> r8 pending, pend_cnt unchanged; flush with set r9 -> pend_cnt=0, r9 not pending.
REQ-042 reset asserted with 3 pending and wr_en high -> all pending cleared, write not performed, SP=524288.
